// File: rtl/seg_pkg.sv
// Shared definitions for the 74HC595 multiplexed 7-segment scan driver.
// Contents:
//   SEG_TAB       - active-high g..a segment patterns for hex digits 0..F
//   scan_state_e  - scan FSM states
//   frame_len()   - clk cycles taken by one digit frame
package seg_pkg;

  // Bit 6..0 = g..a, active-high, before any polarity inversion.
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_HOLD
  } scan_state_e;

  // One LOAD cycle, two sck halves per shifted bit, one rck pulse, then hold.
  function automatic int unsigned frame_len(input int unsigned num_dig,
                                            input int unsigned sck_div,
                                            input int unsigned dig_hold);
    return 1 + 2 * sck_div * (8 + num_dig) + sck_div + dig_hold;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to 7-segment decoder.
// Ports:
//   nibble - 4-bit hex value
//   seg    - active-high segment pattern, bit 6..0 = g..a
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[nibble];

endmodule

// File: rtl/hc595_scan_drv.sv
// Scan driver for a chain of 74HC595 shift registers feeding a multiplexed
// 7-segment display. Each digit frame shifts the segment byte followed by a
// one-hot digit select word, latches it with rck, then idles for DIG_HOLD.
// Ports:
//   clk, rst_n       - system clock, asynchronous active-low reset
//   dat              - hex nibble per digit, nibble k = dat[4k+3:4k]
//   dat_en           - per-digit display enable
//   dot_en           - per-digit decimal point enable
//   blink_en         - per-digit blink enable
//   upd              - strobe capturing dat/dat_en/dot_en/blink_en as pending
//   rck, sck, din    - 74HC595 latch clock, shift clock, serial data
//   scan_done        - one-cycle pulse after the rck of digit 0
module hc595_scan_drv
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIG     = 8,
  parameter int unsigned SCK_DIV     = 4,
  parameter int unsigned DIG_HOLD    = 1000,
  parameter int unsigned BLINK_CYC   = 25_000_000,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4*NUM_DIG-1:0]   dat,
  input  logic [NUM_DIG-1:0]     dat_en,
  input  logic [NUM_DIG-1:0]     dot_en,
  input  logic [NUM_DIG-1:0]     blink_en,
  input  logic                   upd,
  output logic                   rck,
  output logic                   sck,
  output logic                   din,
  output logic                   scan_done
);

  localparam int unsigned W  = 8 + NUM_DIG;
  localparam int unsigned DW = $clog2(NUM_DIG);
  localparam int unsigned BW = $clog2(W);

  localparam logic [DW-1:0] LAST_DIG  = DW'(NUM_DIG - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);
  localparam logic [7:0]    DIV_END   = 8'(SCK_DIV - 1);
  localparam logic [15:0]   HOLD_END  = 16'(DIG_HOLD - 1);
  localparam logic [31:0]   BLINK_END = 32'(BLINK_CYC - 1);

  scan_state_e            state_q, state_d;
  logic [DW-1:0]          dig_q, dig_d;
  logic [7:0]             div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [W-1:0]           word_q, word_d;
  logic [15:0]            hold_q, hold_d;
  logic                   sck_q, sck_d;
  logic                   rck_q, rck_d;
  logic                   din_q, din_d;
  logic                   done_q, done_d;
  logic [31:0]            blink_cnt_q, blink_cnt_d;
  logic                   blink_on_q, blink_on_d;

  logic                   pend_q, pend_d;
  logic [4*NUM_DIG-1:0]   pend_dat_q, pend_dat_d;
  logic [NUM_DIG-1:0]     pend_en_q, pend_en_d;
  logic [NUM_DIG-1:0]     pend_dot_q, pend_dot_d;
  logic [NUM_DIG-1:0]     pend_blk_q, pend_blk_d;

  logic [4*NUM_DIG-1:0]   sh_dat_q, sh_dat_d;
  logic [NUM_DIG-1:0]     sh_en_q, sh_en_d;
  logic [NUM_DIG-1:0]     sh_dot_q, sh_dot_d;
  logic [NUM_DIG-1:0]     sh_blk_q, sh_blk_d;

  logic                   take_pend;
  logic [4*NUM_DIG-1:0]   eff_dat;
  logic [NUM_DIG-1:0]     eff_en, eff_dot, eff_blk;
  logic [3:0]             cur_nib;
  logic [6:0]             cur_seg7;
  logic                   blink_off, blank;
  logic [7:0]             seg_byte, out_seg;
  logic [NUM_DIG-1:0]     sel_vec;
  logic [W-1:0]           load_word;

  // The shadow registers only change at the LOAD of the leftmost digit, so
  // the word built in that same cycle must already see the pending data.
  always_comb begin
    take_pend = (state_q == ST_LOAD) && (dig_q == LAST_DIG) && pend_q;
    eff_dat   = take_pend ? pend_dat_q : sh_dat_q;
    eff_en    = take_pend ? pend_en_q  : sh_en_q;
    eff_dot   = take_pend ? pend_dot_q : sh_dot_q;
    eff_blk   = take_pend ? pend_blk_q : sh_blk_q;
  end

  seg_decode u_seg_decode (
    .nibble (cur_nib),
    .seg    (cur_seg7)
  );

  // Build the frame word for the current digit: segment byte then one-hot select.
  always_comb begin
    cur_nib   = eff_dat[{dig_q, 2'b00} +: 4];
    blink_off = eff_blk[dig_q] & ~blink_on_q;
    blank     = ~eff_en[dig_q] | blink_off;
    seg_byte  = {eff_dot[dig_q] & ~blink_off, cur_seg7 & {7{~blank}}};
    out_seg   = SEG_ACT_LOW ? ~seg_byte : seg_byte;
    sel_vec   = '0;
    sel_vec[dig_q] = 1'b1;
    load_word = {out_seg, sel_vec};
  end

  // Free-running blink timebase, the update mailbox and the scan FSM.
  // A new upd always overwrites the mailbox, so an upd coincident with the
  // boundary LOAD lands in the mailbox after the old contents are consumed.
  always_comb begin
    state_d     = state_q;
    dig_d       = dig_q;
    div_d       = div_q;
    bit_d       = bit_q;
    word_d      = word_q;
    hold_d      = hold_q;
    sck_d       = sck_q;
    rck_d       = rck_q;
    din_d       = din_q;
    done_d      = 1'b0;

    if (blink_cnt_q == BLINK_END) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 32'd1;
      blink_on_d  = blink_on_q;
    end

    pend_d     = pend_q & ~take_pend;
    pend_dat_d = pend_dat_q;
    pend_en_d  = pend_en_q;
    pend_dot_d = pend_dot_q;
    pend_blk_d = pend_blk_q;
    if (upd) begin
      pend_d     = 1'b1;
      pend_dat_d = dat;
      pend_en_d  = dat_en;
      pend_dot_d = dot_en;
      pend_blk_d = blink_en;
    end

    sh_dat_d = eff_dat;
    sh_en_d  = eff_en;
    sh_dot_d = eff_dot;
    sh_blk_d = eff_blk;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
        sck_d   = 1'b0;
        rck_d   = 1'b0;
        din_d   = 1'b0;
      end
      // din for the first bit goes out together with entering SHIFT; the
      // rest of the word is kept pre-shifted so word_q MSB is the next bit.
      ST_LOAD: begin
        word_d  = {load_word[W-2:0], 1'b0};
        din_d   = load_word[W-1];
        sck_d   = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = ST_SHIFT;
      end
      // sck_q doubles as the half-bit phase: low half then high half.
      ST_SHIFT: begin
        if (div_q == DIV_END) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (bit_q == LAST_BIT) begin
            sck_d   = 1'b0;
            din_d   = 1'b0;
            rck_d   = 1'b1;
            state_d = ST_LATCH;
          end else begin
            sck_d  = 1'b0;
            bit_d  = bit_q + 1'b1;
            din_d  = word_q[W-1];
            word_d = {word_q[W-2:0], 1'b0};
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_LATCH: begin
        if (div_q == DIV_END) begin
          div_d   = '0;
          rck_d   = 1'b0;
          done_d  = (dig_q == '0);
          dig_d   = (dig_q == '0) ? LAST_DIG : dig_q - 1'b1;
          hold_d  = '0;
          state_d = (DIG_HOLD == 0) ? ST_LOAD : ST_HOLD;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_END) begin
          state_d = ST_LOAD;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and the registered pin outputs; reset aborts any frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dig_q       <= LAST_DIG;
      div_q       <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      hold_q      <= '0;
      sck_q       <= 1'b0;
      rck_q       <= 1'b0;
      din_q       <= 1'b0;
      done_q      <= 1'b0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      pend_q      <= 1'b0;
      pend_dat_q  <= '0;
      pend_en_q   <= '0;
      pend_dot_q  <= '0;
      pend_blk_q  <= '0;
      sh_dat_q    <= '0;
      sh_en_q     <= '0;
      sh_dot_q    <= '0;
      sh_blk_q    <= '0;
    end else begin
      state_q     <= state_d;
      dig_q       <= dig_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      hold_q      <= hold_d;
      sck_q       <= sck_d;
      rck_q       <= rck_d;
      din_q       <= din_d;
      done_q      <= done_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      pend_q      <= pend_d;
      pend_dat_q  <= pend_dat_d;
      pend_en_q   <= pend_en_d;
      pend_dot_q  <= pend_dot_d;
      pend_blk_q  <= pend_blk_d;
      sh_dat_q    <= sh_dat_d;
      sh_en_q     <= sh_en_d;
      sh_dot_q    <= sh_dot_d;
      sh_blk_q    <= sh_blk_d;
    end
  end

  assign rck       = rck_q;
  assign sck       = sck_q;
  assign din       = din_q;
  assign scan_done = done_q;

endmodule
